uart_boot_loader: RTL and testbench

Loads the program image for the tiny CPU over a UART receive line and writes it, one 32-bit word per write, into the CPU's 16-word instruction memory. Sits directly upstream of the CPU: it holds the CPU stalled while an image is being received and releases it once a complete, valid image is in memory. Receiver, framing FSM and word assembly are all in this block; the instruction memory itself lives beside the CPU.

---
 rtl/uart_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a UART boot image and writes it word by word into instruction memory; define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE, ERROR} st_t;
  logic s1_q, s2_q, s3_q, stb_q, ferr_q;
  rx_t rx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  st_t st_q;
  logic [8:0] n_q, wcnt_q;
  logic [ADDR_W-1:0] nxt_q, addr_q;
  logic [1:0] bidx_q;
  logic [23:0] word_q;
  logic [31:0] wdata_q;
  logic we_q, hold_q, done_q, err_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q;
`endif
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold = hold_q;
  assign load_done = done_q;
  assign load_err = err_q;
  // synchronize the line, detect start edges, sample mid-bit and emit one-cycle byte or framing-error strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
      rx_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      stb_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q <= uart_rx;
      s2_q <= s1_q;
      s3_q <= s2_q;
      stb_q <= 1'b0;
      ferr_q <= 1'b0;
      cnt_q <= cnt_q + 1'b1;
      case (rx_q)
        R_IDLE: begin
          cnt_q <= '0;
          if (s3_q && !s2_q) rx_q <= R_START;
        end
        R_START: if (cnt_q == HALF) begin
          cnt_q <= '0;
          bit_q <= '0;
          rx_q <= s2_q ? R_IDLE : R_DATA;
        end
        R_DATA: if (cnt_q == FULL) begin
          cnt_q <= '0;
          sh_q <= {s2_q, sh_q[7:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) rx_q <= R_STOP;
        end
        R_STOP: if (cnt_q == FULL) begin
          stb_q <= s2_q;
          ferr_q <= !s2_q;
          rx_q <= R_IDLE;
        end
        default: rx_q <= R_IDLE;
      endcase
    end
  end
  // frame parser: header, count, little-endian words, optional checksum; drives memory writes and CPU hold/status
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q <= IDLE;
      n_q <= '0;
      wcnt_q <= '0;
      nxt_q <= '0;
      bidx_q <= '0;
      word_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (ferr_q && st_q != IDLE && st_q != DONE) begin
        st_q <= ERROR;
        err_q <= 1'b1;
        hold_q <= 1'b1;
        done_q <= 1'b0;
      end else if (stb_q) begin
        case (st_q)
          IDLE, DONE, ERROR: if (sh_q == 8'hA5) begin
            st_q <= COUNT;
            hold_q <= 1'b1;
            done_q <= 1'b0;
            err_q <= 1'b0;
          end
          COUNT: if (sh_q == 8'd0 || {1'b0, sh_q} > DEPTH) begin
            st_q <= ERROR;
            err_q <= 1'b1;
          end else begin
            st_q <= DATA;
            n_q <= {1'b0, sh_q};
            wcnt_q <= '0;
            nxt_q <= '0;
            bidx_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
          DATA: begin
            word_q <= {sh_q, word_q[23:8]};
            bidx_q <= bidx_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
            csum_q <= csum_q ^ sh_q;
`endif
            if (bidx_q == 2'd3) begin
              we_q <= 1'b1;
              addr_q <= nxt_q;
              wdata_q <= {sh_q, word_q};
              nxt_q <= nxt_q + 1'b1;
              wcnt_q <= wcnt_q + 1'b1;
              if (wcnt_q + 9'd1 == n_q) begin
`ifdef BOOT_CHECKSUM_EN
                st_q <= CSUM;
`else
                st_q <= DONE;
                done_q <= 1'b1;
                hold_q <= 1'b0;
`endif
              end
            end
          end
`ifdef BOOT_CHECKSUM_EN
          CSUM: if (sh_q == csum_q) begin
            st_q <= DONE;
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end else begin
            st_q <= ERROR;
            err_q <= 1'b1;
          end
`endif
          default: st_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames with a write scoreboard checked by an independent monitor
module tb_uart_boot_loader;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic we, hold, done, err;
  logic [3:0] addr;
  logic [31:0] wdata;
  int total = 0;
  int bad = 0;
  logic [35:0] exp_q[$];
  logic [31:0] img[16];
  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4)) dut (
    .CLK(clk), .RST(rst), .uart_rx(rx), .imem_we(we), .imem_addr(addr),
    .imem_wdata(wdata), .cpu_hold(hold), .load_done(done), .load_err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h expected none", addr, wdata);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({addr, wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h", addr, wdata, e[35:32], e[31:0]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic status(input string name, input logic h, input logic d, input logic e);
    chk({name, "_hold"}, 32'(hold), 32'(h));
    chk({name, "_done"}, 32'(done), 32'(d));
    chk({name, "_err"}, 32'(err), 32'(e));
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic settle();
    repeat (4) @(negedge clk);
  endtask
  task automatic send_image(input int n);
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
`endif
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({4'(k), img[k]});
      for (int j = 0; j < 4; j++) begin
        send_byte(img[k][8*j +: 8]);
`ifdef BOOT_CHECKSUM_EN
        cs ^= img[k][8*j +: 8];
`endif
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(cs);
`endif
    settle();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    status("rst", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    send_byte(8'hA5);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back({4'd0, 32'h00500093});
    send_byte(8'h01);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hC3);
`endif
    settle();
    status("single", 1'b0, 1'b1, 1'b0);
    chk("single_addr_held", 32'(addr), 32'd0);
    chk("single_data_held", wdata, 32'h00500093);
    send_byte(8'hA5);
    settle();
    status("reheader", 1'b1, 1'b0, 1'b0);
    send_byte(8'h10);
    for (int k = 0; k < 16; k++) begin
      img[k] = 32'(k) * 32'h01010101;
      exp_q.push_back({4'(k), img[k]});
      for (int j = 0; j < 4; j++) send_byte(8'(k));
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    settle();
    status("full", 1'b0, 1'b1, 1'b0);
    chk("full_last_addr", 32'(addr), 32'd15);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h93);
    send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    status("midrst", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    img[0] = 32'h11223344;
    img[1] = 32'h12345678;
    send_image(2);
    status("after_rst", 1'b0, 1'b1, 1'b0);
    chk("after_rst_addr", 32'(addr), 32'd1);
`ifdef BOOT_CHECKSUM_EN
    exp_q.push_back({4'd0, 32'h00500093});
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
    send_byte(8'h00);
    settle();
    status("badcs", 1'b1, 1'b0, 1'b1);
    img[0] = 32'h00500093;
    send_image(1);
    status("badcs_retry", 1'b0, 1'b1, 1'b0);
`endif
    send_byte(8'hA5);
    send_byte(8'h00);
    settle();
    status("count0", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    settle();
    status("err_clear", 1'b1, 1'b0, 1'b0);
    send_byte(8'h11);
    settle();
    status("count17", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h93);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50);
    send_byte(8'h00);
    settle();
    status("framing", 1'b1, 1'b0, 1'b1);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
